// File: rtl/dpram_arbiter_if.sv
// Bus bundle for dpram_arbiter: two requesters (A/B) with separate
// write and read handshakes, plus the RAM-side port.
// The slave modport is the arbiter's view. The master modport is the
// view of the surrounding requesters and RAM.
interface dpram_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Requester write side
  logic             WrReqA;
  logic             WrReqB;
  logic [AW-1:0]    WrAddrA;
  logic [AW-1:0]    WrAddrB;
  logic [WIDTH-1:0] WrDataA;
  logic [WIDTH-1:0] WrDataB;
  logic             WrGntA;
  logic             WrGntB;

  // Requester read side
  logic             RdReqA;
  logic             RdReqB;
  logic [AW-1:0]    RdAddrA;
  logic [AW-1:0]    RdAddrB;
  logic             RdGntA;
  logic             RdGntB;
  logic             RdValidA;
  logic             RdValidB;
  logic [WIDTH-1:0] RdDataA;
  logic [WIDTH-1:0] RdDataB;

  // RAM side (registered read, 1-cycle latency on Q)
  logic             WE;
  logic [AW-1:0]    WrAddress;
  logic [WIDTH-1:0] Data;
  logic [AW-1:0]    RdAddress;
  logic [WIDTH-1:0] Q;

  modport slave (
    input  WrReqA, WrReqB, WrAddrA, WrAddrB, WrDataA, WrDataB,
    output WrGntA, WrGntB,
    input  RdReqA, RdReqB, RdAddrA, RdAddrB,
    output RdGntA, RdGntB, RdValidA, RdValidB, RdDataA, RdDataB,
    output WE, WrAddress, Data, RdAddress,
    input  Q
  );

  modport master (
    output WrReqA, WrReqB, WrAddrA, WrAddrB, WrDataA, WrDataB,
    input  WrGntA, WrGntB,
    output RdReqA, RdReqB, RdAddrA, RdAddrB,
    input  RdGntA, RdGntB, RdValidA, RdValidB, RdDataA, RdDataB,
    input  WE, WrAddress, Data, RdAddress,
    output Q
  );
endinterface

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: two-requester round-robin arbiter in front of a
// simple dual-port RAM that has a registered read.
// Writes and reads are arbitrated independently. Read data returns to
// the granted requester exactly two cycles after its grant.
// Optional feature: define DPRAM_ARBITER_BYPASS_EN so that a read and a
// write granted in the same cycle to the same address return the new
// write data instead of the RAM's old contents.
module dpram_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic            Clock,
  input logic            Reset,
  dpram_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Round-robin pick between two requesters, returned as {gnt_b, gnt_a}.
  // On contention the requester that was not granted last time wins.
  function automatic logic [1:0] rr_pick(input logic req_a, input logic req_b,
                                         input req_id_e last);
    logic [1:0] gnt;
    gnt = {req_b, req_a};
    if (req_a && req_b) begin
      gnt = (last == REQ_B) ? 2'b01 : 2'b10;
    end
    return gnt;
  endfunction

  // Priority state and read-return pipeline
  req_id_e          wr_last_q, wr_last_d;
  req_id_e          rd_last_q, rd_last_d;
  logic             tag_vld_p1_q, tag_vld_p1_d;
  req_id_e          tag_id_p1_q, tag_id_p1_d;
  logic             rd_vld_a_p2_q, rd_vld_a_p2_d;
  logic             rd_vld_b_p2_q, rd_vld_b_p2_d;
  logic [WIDTH-1:0] rd_data_a_p2_q, rd_data_a_p2_d;
  logic [WIDTH-1:0] rd_data_b_p2_q, rd_data_b_p2_d;
`ifdef DPRAM_ARBITER_BYPASS_EN
  logic             byp_hit_p1_q, byp_hit_p1_d;
  logic [WIDTH-1:0] byp_data_p1_q, byp_data_p1_d;
`endif

  logic [1:0]       wr_gnt;
  logic [1:0]       rd_gnt;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_word;

  // Combinational grants and RAM-side muxing; all grants are held off during reset
  always_comb begin
    wr_gnt  = 2'b00;
    rd_gnt  = 2'b00;
    if (!Reset) begin
      wr_gnt = rr_pick(bus.WrReqA, bus.WrReqB, wr_last_q);
      rd_gnt = rr_pick(bus.RdReqA, bus.RdReqB, rd_last_q);
    end
    wr_addr = wr_gnt[1] ? bus.WrAddrB : bus.WrAddrA;
    wr_data = wr_gnt[1] ? bus.WrDataB : bus.WrDataA;
    rd_addr = rd_gnt[1] ? bus.RdAddrB : bus.RdAddrA;
  end

  assign bus.WrGntA    = wr_gnt[0];
  assign bus.WrGntB    = wr_gnt[1];
  assign bus.RdGntA    = rd_gnt[0];
  assign bus.RdGntB    = rd_gnt[1];
  assign bus.WE        = |wr_gnt;
  assign bus.WrAddress = wr_addr;
  assign bus.Data      = wr_data;
  assign bus.RdAddress = rd_addr;
  assign bus.RdValidA  = rd_vld_a_p2_q;
  assign bus.RdValidB  = rd_vld_b_p2_q;
  assign bus.RdDataA   = rd_data_a_p2_q;
  assign bus.RdDataB   = rd_data_b_p2_q;

  // Next-state: priority updates, tag pipeline and per-requester read-data capture
  always_comb begin
    wr_last_d = wr_last_q;
    rd_last_d = rd_last_q;
    if (|wr_gnt) begin
      wr_last_d = wr_gnt[1] ? REQ_B : REQ_A;
    end
    if (|rd_gnt) begin
      rd_last_d = rd_gnt[1] ? REQ_B : REQ_A;
    end

    // p0 -> p1: the grant cycle tags the read that the RAM is now fetching
    tag_vld_p1_d = |rd_gnt;
    tag_id_p1_d  = rd_gnt[1] ? REQ_B : REQ_A;

`ifdef DPRAM_ARBITER_BYPASS_EN
    byp_hit_p1_d  = (|wr_gnt) && (|rd_gnt) && (wr_addr == rd_addr);
    byp_data_p1_d = wr_data;
    rd_word       = byp_hit_p1_q ? byp_data_p1_q : bus.Q;
`else
    rd_word       = bus.Q;
`endif

    // p1 -> p2: Q is valid now; steer it to the tagged requester, the other holds
    rd_vld_a_p2_d  = tag_vld_p1_q && (tag_id_p1_q == REQ_A);
    rd_vld_b_p2_d  = tag_vld_p1_q && (tag_id_p1_q == REQ_B);
    rd_data_a_p2_d = rd_vld_a_p2_d ? rd_word : rd_data_a_p2_q;
    rd_data_b_p2_d = rd_vld_b_p2_d ? rd_word : rd_data_b_p2_q;
  end

  // State registers; reset drops in-flight reads and clears returned data
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_last_q      <= REQ_B;
      rd_last_q      <= REQ_B;
      tag_vld_p1_q   <= 1'b0;
      tag_id_p1_q    <= REQ_A;
      rd_vld_a_p2_q  <= 1'b0;
      rd_vld_b_p2_q  <= 1'b0;
      rd_data_a_p2_q <= '0;
      rd_data_b_p2_q <= '0;
`ifdef DPRAM_ARBITER_BYPASS_EN
      byp_hit_p1_q   <= 1'b0;
`endif
    end else begin
      wr_last_q      <= wr_last_d;
      rd_last_q      <= rd_last_d;
      tag_vld_p1_q   <= tag_vld_p1_d;
      tag_id_p1_q    <= tag_id_p1_d;
      rd_vld_a_p2_q  <= rd_vld_a_p2_d;
      rd_vld_b_p2_q  <= rd_vld_b_p2_d;
      rd_data_a_p2_q <= rd_data_a_p2_d;
      rd_data_b_p2_q <= rd_data_b_p2_d;
`ifdef DPRAM_ARBITER_BYPASS_EN
      byp_hit_p1_q   <= byp_hit_p1_d;
`endif
    end
  end

`ifdef DPRAM_ARBITER_BYPASS_EN
  // Bypass data is qualified by byp_hit_p1_q, so it needs no reset
  always_ff @(posedge Clock) begin
    byp_data_p1_q <= byp_data_p1_d;
  end
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Testbench for dpram_arbiter: directed scenarios followed by
// randomized traffic. A reference model predicts grants and RAM-side
// outputs each cycle, and queues the expected read returns. A monitor
// compares those returns against RdValid/RdData.
module tb_dpram_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpram_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dpram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Attached RAM: registered read, old data on a same-address read/write
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.WE) ram[bus.WrAddress] <= bus.Data;
    bus.Q <= ram[bus.RdAddress];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic             wr_last_b = 1'b1;
  logic             rd_last_b = 1'b1;
  logic [WIDTH-1:0] exp_a = '0;
  logic [WIDTH-1:0] exp_b = '0;
  logic             mon_en = 1'b0;
  logic             rst_seen = 1'b0;
  logic [1:0]       gw, gr;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Two-way round robin from the requirements, result as {B, A}
  function automatic logic [1:0] arb_pick(input logic ra, input logic rb, input logic last_b);
    if (ra && rb) return last_b ? 2'b01 : 2'b10;
    return {rb, ra};
  endfunction

  // One clock cycle: predict and check this cycle's outputs, then advance the model
  task automatic step();
    logic [AW-1:0]    waddr, raddr;
    logic [WIDTH-1:0] wdata, d;
    exp_t             e;
    @(negedge clk);
    if (rst) begin
      gw = 2'b00;
      gr = 2'b00;
      rst_seen = 1'b1;
    end else begin
      gw = arb_pick(bus.WrReqA, bus.WrReqB, wr_last_b);
      gr = arb_pick(bus.RdReqA, bus.RdReqB, rd_last_b);
    end
    waddr = gw[1] ? bus.WrAddrB : bus.WrAddrA;
    wdata = gw[1] ? bus.WrDataB : bus.WrDataA;
    raddr = gr[1] ? bus.RdAddrB : bus.RdAddrA;
    chk("wr_gnt", {30'd0, bus.WrGntB, bus.WrGntA}, {30'd0, gw});
    chk("rd_gnt", {30'd0, bus.RdGntB, bus.RdGntA}, {30'd0, gr});
    chk("ram_wr", {19'd0, bus.WE, bus.WrAddress, bus.Data}, {19'd0, |gw, waddr, wdata});
    chk("ram_rd_addr", {28'd0, bus.RdAddress}, {28'd0, raddr});
    if (|gw) wr_last_b = gw[1];
    if (|gr) begin
      rd_last_b = gr[1];
      d = model_mem[raddr];
`ifdef DPRAM_ARBITER_BYPASS_EN
      if ((|gw) && (waddr == raddr)) d = wdata;
`endif
      e.id = gr[1];
      e.data = d;
      e.due = cyc + 2;
      exp_q.push_back(e);
    end
    if (|gw) model_mem[waddr] = wdata;
    @(posedge clk);
    #1;
    if (rst_seen) begin
      rst_seen = 1'b0;
      exp_q.delete();
      exp_a = '0;
      exp_b = '0;
      wr_last_b = 1'b1;
      rd_last_b = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic clear_reqs();
    bus.WrReqA = 1'b0; bus.WrReqB = 1'b0;
    bus.RdReqA = 1'b0; bus.RdReqB = 1'b0;
  endtask

  // Monitor: every read return must match the oldest queued expectation and be due now
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        chk("rd_valid_missing", 32'd0, {31'd0, exp_q[0].id} + 32'd1);
        void'(exp_q.pop_front());
      end
      if (bus.RdValidA || bus.RdValidB) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          chk("rd_valid_spurious", {30'd0, bus.RdValidB, bus.RdValidA}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_valid_id", {30'd0, bus.RdValidB, bus.RdValidA}, e.id ? 32'd2 : 32'd1);
          if (e.id) exp_b = e.data;
          else      exp_a = e.data;
        end
      end
      chk("rd_data_a", {24'd0, bus.RdDataA}, {24'd0, exp_a});
      chk("rd_data_b", {24'd0, bus.RdDataB}, {24'd0, exp_b});
    end
  end

  initial begin
    clear_reqs();
    bus.WrAddrA = '0; bus.WrAddrB = '0; bus.WrDataA = '0; bus.WrDataB = '0;
    bus.RdAddrA = '0; bus.RdAddrB = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Fill the RAM through requester A
    for (int a = 0; a < DEPTH; a++) begin
      bus.WrReqA = 1'b1;
      bus.WrAddrA = AW'(a);
      bus.WrDataA = WIDTH'($urandom);
      if (a == 5) bus.WrDataA = 8'h11;
      step();
    end
    clear_reqs();
    idle(1);

    // Write 0x5A to address 3 from A, then B reads it back
    reset_dut();
    bus.WrReqA = 1'b1; bus.WrAddrA = 4'd3; bus.WrDataA = 8'h5A;
    step();
    clear_reqs();
    bus.RdReqB = 1'b1; bus.RdAddrB = 4'd3;
    step();
    clear_reqs();
    idle(3);
    chk("write_then_read_b", {24'd0, bus.RdDataB}, 32'h5A);
    chk("write_then_read_a_valid", {31'd0, bus.RdValidA}, 32'd0);

    // Write contention held for 4 cycles after reset
    reset_dut();
    bus.WrReqA = 1'b1; bus.WrReqB = 1'b1;
    bus.WrAddrA = 4'd8; bus.WrAddrB = 4'd9;
    bus.WrDataA = 8'hA8; bus.WrDataB = 8'hB9;
    idle(4);
    clear_reqs();

    // Read contention held for 4 cycles, A on address 1, B on address 2
    reset_dut();
    bus.RdReqA = 1'b1; bus.RdReqB = 1'b1;
    bus.RdAddrA = 4'd1; bus.RdAddrB = 4'd2;
    idle(4);
    clear_reqs();
    idle(3);

    // Same-cycle write and read of address 5 (holds 0x11)
    bus.WrReqA = 1'b1; bus.WrAddrA = 4'd5; bus.WrDataA = 8'hC3;
    bus.RdReqA = 1'b1; bus.RdAddrA = 4'd5;
    step();
    clear_reqs();
    idle(3);
`ifdef DPRAM_ARBITER_BYPASS_EN
    chk("same_cycle_rw", {24'd0, bus.RdDataA}, 32'hC3);
`else
    chk("same_cycle_rw", {24'd0, bus.RdDataA}, 32'h11);
`endif

    // Read granted, then reset in the next cycle; then a fresh contention
    bus.RdReqB = 1'b1; bus.RdAddrB = 4'd7;
    step();
    clear_reqs();
    reset_dut();
    idle(3);
    bus.WrReqA = 1'b1; bus.WrReqB = 1'b1;
    bus.WrAddrA = 4'd10; bus.WrAddrB = 4'd11;
    step();
    clear_reqs();
    idle(2);

    // Randomized traffic: requesters hold until granted, occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (!bus.WrReqA && $urandom_range(0, 2) == 0) begin
        bus.WrReqA = 1'b1; bus.WrAddrA = AW'($urandom); bus.WrDataA = WIDTH'($urandom);
      end
      if (!bus.WrReqB && $urandom_range(0, 2) == 0) begin
        bus.WrReqB = 1'b1; bus.WrAddrB = AW'($urandom); bus.WrDataB = WIDTH'($urandom);
      end
      if (!bus.RdReqA && $urandom_range(0, 1) == 0) begin
        bus.RdReqA = 1'b1; bus.RdAddrA = AW'($urandom);
      end
      if (!bus.RdReqB && $urandom_range(0, 1) == 0) begin
        bus.RdReqB = 1'b1; bus.RdAddrB = AW'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        reset_dut();
      end else begin
        step();
        if (gw[0]) bus.WrReqA = 1'b0;
        if (gw[1]) bus.WrReqB = 1'b0;
        if (gr[0]) bus.RdReqA = 1'b0;
        if (gr[1]) bus.RdReqB = 1'b0;
      end
    end
    clear_reqs();
    idle(4);
    chk("pending_reads_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
